// File: rtl/mips_lsu.sv
// Load/store unit: drives a word-only data memory, adding big-endian byte and
// halfword accesses. Sub-word stores run as read-modify-write.
module mips_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              signal_mem_write,
    output logic              signal_mem_read,
    input  logic [31:0]       mem_read_data,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              store_q, store_d;
    logic              unsigned_q, unsigned_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              accept;
    logic              req_err;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_ext;
    logic [31:0]       merged;

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE. resp_valid is a
    // single-cycle pulse with no backpressure.
    always_comb begin
        accept  = req_valid && req_ready_q;
        req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

        case (off_q)
            2'd0:    lane_byte = mem_read_data[31:24];
            2'd1:    lane_byte = mem_read_data[23:16];
            2'd2:    lane_byte = mem_read_data[15:8];
            default: lane_byte = mem_read_data[7:0];
        endcase
        lane_half = off_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];

        case (size_q)
            SZ_BYTE: load_ext = {{24{~unsigned_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = {{16{~unsigned_q & lane_half[15]}}, lane_half};
            default: load_ext = mem_read_data;
        endcase

        // Big-endian lane merge: offset 0 lives in the most significant bits.
        merged = mem_read_data;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[15:0] = wdata_q;
        end else begin
            merged[31:16] = wdata_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        off_d            = off_q;
        size_d           = size_q;
        store_d          = store_q;
        unsigned_d       = unsigned_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    off_d      = req_addr[1:0];
                    size_d     = req_size;
                    store_d    = req_store;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata[15:0];
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else begin
                        mem_address_d = {2'b00, req_addr[ADDR_W-1:2]};
                        if (req_store && req_size == SZ_WORD) begin
                            mem_write_data_d = req_wdata;
                            state_d          = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (store_q) begin
                    mem_write_data_d = merged;
                    state_d          = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        resp_error_d = (state_q == ST_IDLE) && accept && req_err;
        resp_rdata_d = (state_q == ST_READ && !store_q) ? load_ext : 32'd0;
        mem_read_d   = (state_d == ST_READ);
        mem_write_d  = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            off_q            <= 2'd0;
            size_q           <= 2'd0;
            store_q          <= 1'b0;
            unsigned_q       <= 1'b0;
            wdata_q          <= 16'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_error_q     <= 1'b0;
            resp_rdata_q     <= 32'd0;
            mem_address_q    <= '0;
            mem_write_data_q <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            off_q            <= off_d;
            size_q           <= size_d;
            store_q          <= store_d;
            unsigned_q       <= unsigned_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_error_q     <= resp_error_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_error       = resp_error_q;
    assign resp_rdata       = resp_rdata_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;
    assign signal_mem_read  = mem_read_q;
    assign signal_mem_write = mem_write_q;
    assign dbg_state        = state_q;

endmodule
